// File: rtl/mem_req_master.sv
// mem_req_master: initiator side of the memory-system interface.
// Buffers word read/write requests in a small FIFO, runs one memory access at a
// time (strobe, wait for Done or timeout) and returns data/hit/error on a
// valid/ready response port. Also keeps saturating access and hit counters.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   req_valid/req_ready             request handshake; req_wr/req_addr/req_wdata
//   rsp_valid/rsp_ready             response handshake; rsp_rdata/rsp_hit/rsp_err
//   mem_Addr/mem_DataIn/mem_Rd/mem_Wr         to memory (all registered)
//   mem_DataOut/mem_Done/mem_Stall/mem_CacheHit  from memory
//   req_count/hit_count             completed accesses / accesses that hit
module mem_req_master #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_hit,
  output logic          rsp_err,
  output logic [31:0]   mem_Addr,
  output logic [31:0]   mem_DataIn,
  output logic          mem_Rd,
  output logic          mem_Wr,
  input  logic [31:0]   mem_DataOut,
  input  logic          mem_Done,
  input  logic          mem_Stall,
  input  logic          mem_CacheHit,
  output logic [CW-1:0] req_count,
  output logic [CW-1:0] hit_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  // Request FIFO: {wr, addr, wdata}
  logic [64:0]   q_mem [DEPTH];
  logic [PW-1:0] q_wptr_q, q_rptr_q;
  logic [PW:0]   q_cnt_q;
  logic          q_empty, q_full, q_push, q_pop;
  logic          head_wr;
  logic [31:0]   head_addr, head_wdata;

  assign q_empty   = (q_cnt_q == '0);
  assign q_full    = (q_cnt_q == (PW + 1)'(DEPTH));
  assign req_ready = !q_full;
  assign q_push    = req_valid && req_ready;
  assign q_pop     = rsp_valid && rsp_ready;
  assign {head_wr, head_addr, head_wdata} = q_mem[q_rptr_q];

  always_ff @(posedge clk) begin
    if (q_push) q_mem[q_wptr_q] <= {req_wr, req_addr, req_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_wptr_q <= '0;
      q_rptr_q <= '0;
      q_cnt_q  <= '0;
    end else begin
      if (q_push) q_wptr_q <= q_wptr_q + PW'(1);
      if (q_pop)  q_rptr_q <= q_rptr_q + PW'(1);
      case ({q_push, q_pop})
        2'b10:   q_cnt_q <= q_cnt_q + (PW + 1)'(1);
        2'b01:   q_cnt_q <= q_cnt_q - (PW + 1)'(1);
        default: q_cnt_q <= q_cnt_q;
      endcase
    end
  end

  // Access FSM
  state_e        state_q, state_d;
  logic          rd_q, rd_d, wr_q, wr_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          hit_q, hit_d, err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [CW-1:0] req_cnt_q, req_cnt_d, hit_cnt_q, hit_cnt_d;
  logic          capture;

  always_comb begin
    state_d   = state_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    hit_d     = hit_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    req_cnt_d = req_cnt_q;
    hit_cnt_d = hit_cnt_q;
    capture   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!q_empty) begin
          if (head_addr[1:0] != 2'b00) begin
            state_d = StResp;
            err_d   = 1'b1;
            rdata_d = '0;
            hit_d   = 1'b0;
          end else begin
            addr_d  = head_addr;
            wdata_d = head_wdata;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        // Strobe is a flop: it goes high the cycle after Stall is seen low and
        // that strobe cycle is where a zero-latency Done is sampled.
        if (rd_q || wr_q) begin
          if (mem_Done) begin
            capture = 1'b1;
          end else begin
            state_d = StWait;
            tmo_d   = '0;
          end
        end else if (!mem_Stall) begin
          rd_d = !head_wr;
          wr_d = head_wr;
        end
      end
      StWait: begin
        if (mem_Done) begin
          capture = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TW'(TIMEOUT)) begin
            state_d = StResp;
            err_d   = 1'b1;
            rdata_d = '0;
            hit_d   = 1'b0;
          end
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (capture) begin
      state_d = StResp;
      rdata_d = head_wr ? 32'h0 : mem_DataOut;
      hit_d   = mem_CacheHit;
      err_d   = 1'b0;
      if (req_cnt_q != '1) req_cnt_d = req_cnt_q + CW'(1);
      if (mem_CacheHit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      hit_q     <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
      req_cnt_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      hit_q     <= hit_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      req_cnt_q <= req_cnt_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign rsp_valid  = (state_q == StResp);
  assign rsp_rdata  = rdata_q;
  assign rsp_hit    = hit_q;
  assign rsp_err    = err_q;
  assign mem_Addr   = addr_q;
  assign mem_DataIn = wdata_q;
  assign mem_Rd     = rd_q;
  assign mem_Wr     = wr_q;
  assign req_count  = req_cnt_q;
  assign hit_count  = hit_cnt_q;

endmodule
